regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_pkg.sv | 13 +
 rtl/wb_fifo.sv | 82 ++++++++
 rtl/regfile_writeback.sv | 122 ++++++++++++
 tb/tb_regfile_writeback.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the register-file writeback queue
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_BUS_W  = 32;
    localparam int REG_ZERO   = 0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_BUS_W-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - pending-write queue: ordered dual push, single pop, age-ordered entry view
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int ADDR  = REG_ADDR_W,
    parameter int BUS_W = REG_BUS_W,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push0,
    input  logic [ADDR-1:0]             push0_addr,
    input  logic [BUS_W-1:0]            push0_data,
    input  logic                        push1,
    input  logic [ADDR-1:0]             push1_addr,
    input  logic [BUS_W-1:0]            push1_data,
    input  logic                        pop,
    output logic [ADDR-1:0]             head_addr,
    output logic [BUS_W-1:0]            head_data,
    output logic [CW-1:0]               count,
    output logic [DEPTH-1:0]            view_vld,
    output logic [DEPTH-1:0][ADDR-1:0]  view_addr,
    output logic [DEPTH-1:0][BUS_W-1:0] view_data
);

    logic [ADDR-1:0]  addr_q [DEPTH];
    logic [BUS_W-1:0] data_q [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    wptr1;
    logic             pop_eff;

    // push1 lands right behind push0 when both are taken, keeping push0 the older entry
    assign wptr1   = wptr + PW'(push0);
    assign pop_eff = pop && (count != '0);

    // storage writes; slots need no reset because count decides what is valid
    always_ff @(posedge clk) begin
        if (push0) begin
            addr_q[wptr] <= push0_addr;
            data_q[wptr] <= push0_data;
        end
        if (push1) begin
            addr_q[wptr1] <= push1_addr;
            data_q[wptr1] <= push1_data;
        end
    end

    // pointers wrap naturally at DEPTH (power of two); count tells full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PW'(push0) + PW'(push1);
            rptr  <= rptr + PW'(pop_eff);
            count <= count + CW'(push0) + CW'(push1) - CW'(pop_eff);
        end
    end

    assign head_addr = addr_q[rptr];
    assign head_data = data_q[rptr];

    // oldest-first view of the live entries for the bypass search
    always_comb begin
        logic [PW-1:0] idx;
        view_vld  = '0;
        view_addr = '0;
        view_data = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx          = rptr + PW'(i);
            view_vld[i]  = (CW'(i) < count);
            view_addr[i] = addr_q[idx];
            view_data[i] = data_q[idx];
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - merges load and ALU results into one register-file write port; REGFILE_WB_BYPASS_EN adds pending-write bypass
module regfile_writeback
    import regfile_pkg::*;
#(
    parameter int ADDR  = REG_ADDR_W,
    parameter int BUS_W = REG_BUS_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic [ADDR-1:0]  mem_addr,
    input  logic [BUS_W-1:0] mem_data,
    output logic             mem_ready,
    input  logic             alu_valid,
    input  logic [ADDR-1:0]  alu_addr,
    input  logic [BUS_W-1:0] alu_data,
    output logic             alu_ready,
`ifdef REGFILE_WB_BYPASS_EN
    input  logic [ADDR-1:0]  rs_addr,
    input  logic [ADDR-1:0]  rt_addr,
    output logic             rs_hit,
    output logic [BUS_W-1:0] rs_fwd,
    output logic             rt_hit,
    output logic [BUS_W-1:0] rt_fwd,
`endif
    output logic             r_write,
    output logic [ADDR-1:0]  rd_addr,
    output logic [BUS_W-1:0] rd_w_data
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR-1:0] ZERO = ADDR'(REG_ZERO);

    logic [CW-1:0]               count;
    logic [CW-1:0]               free;
    logic                        push_mem;
    logic                        push_alu;
    logic [ADDR-1:0]             head_addr;
    logic [BUS_W-1:0]            head_data;
    logic [DEPTH-1:0]            view_vld;
    logic [DEPTH-1:0][ADDR-1:0]  view_addr;
    logic [DEPTH-1:0][BUS_W-1:0] view_data;

    // readiness uses only registered occupancy, so a same-edge pop never counts as space
    assign free      = CW'(DEPTH) - count;
    assign mem_ready = !rst && (free >= CW'(1));
    assign alu_ready = !rst && ((free >= CW'(2)) || ((free == CW'(1)) && !mem_valid));

    // register 0 writes are acknowledged but dropped
    assign push_mem = mem_valid && mem_ready && (mem_addr != ZERO);
    assign push_alu = alu_valid && alu_ready && (alu_addr != ZERO);

    wb_fifo #(
        .ADDR  (ADDR),
        .BUS_W (BUS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push0      (push_mem),
        .push0_addr (mem_addr),
        .push0_data (mem_data),
        .push1      (push_alu),
        .push1_addr (alu_addr),
        .push1_data (alu_data),
        .pop        (count != '0),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (count),
        .view_vld   (view_vld),
        .view_addr  (view_addr),
        .view_data  (view_data)
    );

    // output stage: retire one entry per cycle, hold address/data when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write   <= 1'b0;
            rd_addr   <= '0;
            rd_w_data <= '0;
        end else if (count != '0) begin
            r_write   <= 1'b1;
            rd_addr   <= head_addr;
            rd_w_data <= head_data;
        end else begin
            r_write   <= 1'b0;
        end
    end

`ifdef REGFILE_WB_BYPASS_EN
    // youngest match wins: output stage first, then queue oldest to youngest overwriting
    function automatic logic [BUS_W:0] lookup(input logic [ADDR-1:0] a);
        logic             hit;
        logic [BUS_W-1:0] fwd;
        hit = 1'b0;
        fwd = '0;
        if (r_write && (rd_addr == a)) begin
            hit = 1'b1;
            fwd = rd_w_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (view_vld[i] && (view_addr[i] == a)) begin
                hit = 1'b1;
                fwd = view_data[i];
            end
        end
        if (rst || (a == ZERO)) begin
            hit = 1'b0;
            fwd = '0;
        end
        return {hit, fwd};
    endfunction

    assign {rs_hit, rs_fwd} = lookup(rs_addr);
    assign {rt_hit, rt_fwd} = lookup(rt_addr);
`else
    logic unused_view;
    assign unused_view = ^{view_vld, view_addr, view_data};
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - scoreboard bench for regfile_writeback
module tb_regfile_writeback;
    import regfile_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, alu_valid;
    logic [4:0]  mem_addr, alu_addr;
    logic [31:0] mem_data, alu_data;
    logic        mem_ready, alu_ready;
    logic        r_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_w_data;
`ifdef REGFILE_WB_BYPASS_EN
    logic [4:0]  rs_addr, rt_addr;
    logic        rs_hit, rt_hit;
    logic [31:0] rs_fwd, rt_fwd;
`endif

    int checks = 0;
    int errors = 0;

    wb_entry_t sb[$];
    wb_entry_t mem_q[$];
    wb_entry_t alu_q[$];
    wb_entry_t last_out;
    logic      last_rw;

    always #5 clk = ~clk;

    regfile_writeback #(.ADDR(5), .BUS_W(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
`ifdef REGFILE_WB_BYPASS_EN
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_hit    (rs_hit),
        .rs_fwd    (rs_fwd),
        .rt_hit    (rt_hit),
        .rt_fwd    (rt_fwd),
`endif
        .r_write   (r_write),
        .rd_addr   (rd_addr),
        .rd_w_data (rd_w_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

`ifdef REGFILE_WB_BYPASS_EN
    function automatic logic [32:0] exp_lookup(input logic [4:0] a);
        if (a == 5'd0) return 33'd0;
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].addr == a) return {1'b1, sb[i].data};
        if (last_rw && last_out.addr == a) return {1'b1, last_out.data};
        return 33'd0;
    endfunction

    task automatic check_bypass();
        logic [32:0] e;
        e = exp_lookup(rs_addr);
        check("rs_hit", rs_hit, e[32]);
        check("rs_fwd", rs_fwd, e[31:0]);
        e = exp_lookup(rt_addr);
        check("rt_hit", rt_hit, e[32]);
        check("rt_fwd", rt_fwd, e[31:0]);
    endtask
`endif

    // called one unit after an edge with inputs already driven; ends one unit after the next edge
    task automatic step(output logic m_acc, output logic a_acc);
        int        free;
        logic      exp_mr, exp_ar, do_pop;
        wb_entry_t e;
        #1;
        free   = DEPTH - sb.size();
        exp_mr = (free >= 1);
        exp_ar = (free >= 2) || (free == 1 && !mem_valid);
        check("mem_ready", mem_ready, exp_mr);
        check("alu_ready", alu_ready, exp_ar);
        m_acc  = mem_valid && exp_mr;
        a_acc  = alu_valid && exp_ar;
        do_pop = (sb.size() > 0);
        e      = '0;
        if (do_pop) e = sb.pop_front();
        if (m_acc && mem_addr != 5'd0) sb.push_back('{mem_addr, mem_data});
        if (a_acc && alu_addr != 5'd0) sb.push_back('{alu_addr, alu_data});
        @(posedge clk);
        #1;
        check("r_write", r_write, do_pop);
        if (do_pop) begin
            check("rd_addr", rd_addr, e.addr);
            check("rd_w_data", rd_w_data, e.data);
            last_out = e;
        end
        last_rw = do_pop;
`ifdef REGFILE_WB_BYPASS_EN
        check_bypass();
`endif
    endtask

    task automatic idle(input int n);
        logic ma, aa;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        for (int i = 0; i < n; i++) step(ma, aa);
    endtask

    // offers held until accepted; gap_pct inserts random idle cycles
    task automatic drain(input int gap_pct);
        int   n = 0;
        logic ma, aa;
        while ((mem_q.size() > 0 || alu_q.size() > 0 || sb.size() > 0) && n < 400) begin
            mem_valid = (mem_q.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
            alu_valid = (alu_q.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
            if (mem_q.size() > 0) begin mem_addr = mem_q[0].addr; mem_data = mem_q[0].data; end
            if (alu_q.size() > 0) begin alu_addr = alu_q[0].addr; alu_data = alu_q[0].data; end
`ifdef REGFILE_WB_BYPASS_EN
            rs_addr = 5'($urandom_range(0, 7));
            rt_addr = 5'($urandom_range(0, 7));
`endif
            step(ma, aa);
            if (ma) void'(mem_q.pop_front());
            if (aa) void'(alu_q.pop_front());
            n++;
        end
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        check("drain", mem_q.size() + alu_q.size() + sb.size(), 0);
        idle(1);
    endtask

    initial begin
        logic ma, aa;
        rst = 1'b1;
        mem_valid = 1'b0; alu_valid = 1'b0;
        mem_addr = '0; alu_addr = '0; mem_data = '0; alu_data = '0;
`ifdef REGFILE_WB_BYPASS_EN
        rs_addr = 5'd7; rt_addr = 5'd0;
`endif
        last_rw = 1'b0;
        last_out = '0;
        #1;
        check("rst_r_write", r_write, 1'b0);
        check("rst_rd_addr", rd_addr, 5'd0);
        check("rst_rd_w_data", rd_w_data, 32'd0);
        check("rst_mem_ready", mem_ready, 1'b0);
        check("rst_alu_ready", alu_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // simultaneous mem and alu into empty queue
        mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'hAAAA0001;
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h0000BEEF;
        step(ma, aa);
        check("both_acc", {ma, aa}, 2'b11);
        idle(3);

        // address 0 is acknowledged but never written
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF;
        step(ma, aa);
        check("zero_acc", aa, 1'b1);
        idle(2);

        // five alu offers competing with loads: fills to free==1 and stalls alu
        for (int i = 0; i < 5; i++) alu_q.push_back('{5'(10 + i), 32'hA000 + i});
        for (int i = 0; i < 3; i++) mem_q.push_back('{5'(20 + i), 32'hB000 + i});
        drain(0);

`ifdef REGFILE_WB_BYPASS_EN
        // two pending writes to reg 7: youngest forwarded
        rs_addr = 5'd7; rt_addr = 5'd0;
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h11;
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h22;
        step(ma, aa);
        check("byp_rs_hit", rs_hit, 1'b1);
        check("byp_rs_fwd", rs_fwd, 32'h22);
        check("byp_rt_hit", rt_hit, 1'b0);
        idle(3);
`endif

        // random traffic with address 0 mixed in
        for (int i = 0; i < 30; i++) begin
            mem_q.push_back('{5'($urandom_range(0, 7)), $urandom});
            alu_q.push_back('{5'($urandom_range(0, 7)), $urandom});
        end
        drain(30);

        // reset with three entries pending
        mem_valid = 1'b1; mem_addr = 5'd1; mem_data = 32'h101;
        alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h202;
        step(ma, aa);
        mem_addr = 5'd3; mem_data = 32'h303;
        alu_addr = 5'd5; alu_data = 32'h505;
        step(ma, aa);
        check("pend_cnt", sb.size(), 3);
        mem_valid = 1'b0; alu_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_r_write", r_write, 1'b0);
        check("mid_rst_rd_addr", rd_addr, 5'd0);
        check("mid_rst_mem_ready", mem_ready, 1'b0);
        check("mid_rst_alu_ready", alu_ready, 1'b0);
`ifdef REGFILE_WB_BYPASS_EN
        check("mid_rst_rs_hit", rs_hit, 1'b0);
`endif
        sb.delete();
        last_rw = 1'b0;
        last_out = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'h909;
        step(ma, aa);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
